// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: fetch/load-store requester handshakes and the shared bus, seen by the arbiter (master) and its environment (slave)
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_write;
    logic [DATA_W-1:0] f_wdata;
    logic              f_gnt;
    logic              f_done;
    logic              f_err;
    logic [DATA_W-1:0] f_rdata;
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic              m_write;
    logic [DATA_W-1:0] m_wdata;
    logic              m_gnt;
    logic              m_done;
    logic              m_err;
    logic [DATA_W-1:0] m_rdata;
    logic [ADDR_W-1:0] bus_address;
    logic              bus_write;
    logic [1:0]        bus_trans;
    logic [DATA_W-1:0] bus_write_data;
    logic              bus_ready;
    logic              bus_response;
    logic [DATA_W-1:0] bus_read_data;

    modport master (
        input  f_req, f_addr, f_write, f_wdata, m_req, m_addr, m_write, m_wdata,
        input  bus_ready, bus_response, bus_read_data,
        output f_gnt, f_done, f_err, f_rdata, m_gnt, m_done, m_err, m_rdata,
        output bus_address, bus_write, bus_trans, bus_write_data
    );

    modport slave (
        output f_req, f_addr, f_write, f_wdata, m_req, m_addr, m_write, m_wdata,
        output bus_ready, bus_response, bus_read_data,
        input  f_gnt, f_done, f_err, f_rdata, m_gnt, m_done, m_err, m_rdata,
        input  bus_address, bus_write, bus_trans, bus_write_data
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: arbitrates fetch (f) and load/store (m) onto one single-outstanding bus; ARB_ROUND_ROBIN_EN makes ties go to the non-owner, otherwise m wins ties
module bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic            clock,
    input logic            reset,
    bus_arbiter_if.master  b
);
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic       RESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic {OWN_F, OWN_M} owner_t;

    state_t state;
    owner_t owner;
    logic   pick_m;
    logic   err;

    assign err = b.bus_response == RESP_ERROR;
`ifdef ARB_ROUND_ROBIN_EN
    assign pick_m = b.m_req && (!b.f_req || owner == OWN_F);
`else
    assign pick_m = b.m_req;
`endif

    // grant in IDLE, one address cycle, then wait in DATA for bus_ready and report to the owner
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            owner            <= OWN_M;
            b.bus_address    <= {ADDR_W{1'b0}};
            b.bus_write      <= 1'b0;
            b.bus_trans      <= TRANS_IDLE;
            b.bus_write_data <= {DATA_W{1'b0}};
            b.f_gnt          <= 1'b0;
            b.f_done         <= 1'b0;
            b.f_err          <= 1'b0;
            b.f_rdata        <= {DATA_W{1'b0}};
            b.m_gnt          <= 1'b0;
            b.m_done         <= 1'b0;
            b.m_err          <= 1'b0;
            b.m_rdata        <= {DATA_W{1'b0}};
        end else begin
            b.f_gnt  <= 1'b0;
            b.m_gnt  <= 1'b0;
            b.f_done <= 1'b0;
            b.m_done <= 1'b0;
            b.f_err  <= 1'b0;
            b.m_err  <= 1'b0;
            case (state)
                IDLE: if (b.bus_ready && (b.f_req || b.m_req)) begin
                    owner            <= pick_m ? OWN_M : OWN_F;
                    b.bus_address    <= pick_m ? b.m_addr : b.f_addr;
                    b.bus_write      <= pick_m ? b.m_write : b.f_write;
                    b.bus_write_data <= pick_m ? b.m_wdata : b.f_wdata;
                    b.bus_trans      <= TRANS_NONSEQ;
                    b.m_gnt          <= pick_m;
                    b.f_gnt          <= !pick_m;
                    state            <= ADDR;
                end
                ADDR: begin
                    b.bus_trans <= TRANS_IDLE;
                    state       <= DATA;
                end
                DATA: if (b.bus_ready) begin
                    if (owner == OWN_M) begin
                        b.m_done  <= 1'b1;
                        b.m_err   <= err;
                        b.m_rdata <= err ? {DATA_W{1'b0}} : b.bus_read_data;
                    end else begin
                        b.f_done  <= 1'b1;
                        b.f_err   <= err;
                        b.f_rdata <= err ? {DATA_W{1'b0}} : b.bus_read_data;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed requests with a queued scoreboard checked by an independent grant/done monitor
module tb_bus_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif();
    bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clock(clock), .reset(reset), .b(bif));

    typedef struct {
        logic        kind;
        logic        who;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_any_gnt = -100;
    int          last_gnt[2];
    logic [31:0] last_rd[2];
    int          cfg_wait = 0;
    logic [31:0] cfg_err_addr = 32'hFFFF_FFFF;
    logic        hold_ready = 1'b0;
    logic        first_who;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a == 32'h100 ? 32'hDEAD_BEEF : (~a ^ 32'h0F0F_0000);
    endfunction

    function automatic void push_gnt(input logic who, input logic [31:0] a, input logic wr, input logic [31:0] wd);
        expq.push_back('{1'b0, who, a, wr, wd, 1'b0, 0});
    endfunction

    function automatic void push_done(input logic who, input logic [31:0] d, input logic err, input int lat);
        expq.push_back('{1'b1, who, 32'h0, 1'b0, d, err, lat});
    endfunction

    function automatic void push_xfer(input logic who, input logic [31:0] a, input logic wr, input logic [31:0] wd, input int lat);
        push_gnt(who, a, wr, wd);
        push_done(who, rd_model(a), 1'b0, lat);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic on_evt(input logic kind, input logic who);
        exp_t e;
        if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event kind=%0d who=%0d actual=event required=none t=%0t", kind, who, $time);
            return;
        end
        e = expq.pop_front();
        chk("event_kind", 32'(kind), 32'(e.kind));
        chk("event_owner", 32'(who), 32'(e.who));
        if (!kind) begin
            chk("bus_address", bif.bus_address, e.addr);
            chk("bus_write", 32'(bif.bus_write), 32'(e.wr));
            chk("bus_write_data", bif.bus_write_data, e.data);
            chk("bus_trans_nonseq", 32'(bif.bus_trans), 32'd2);
            chk("grant_spacing_ge3", 32'(cyc - last_any_gnt >= 3), 32'd1);
            last_any_gnt = cyc;
            last_gnt[who] = cyc;
        end else begin
            chk("rdata", who ? bif.m_rdata : bif.f_rdata, e.data);
            chk("err", 32'(who ? bif.m_err : bif.f_err), 32'(e.err));
            chk("done_latency", 32'(cyc - last_gnt[who]), 32'(e.lat));
            chk("other_rdata_kept", who ? bif.f_rdata : bif.m_rdata, last_rd[!who]);
            last_rd[who] = e.data;
        end
    endtask

    task automatic do_req(input logic who, input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        logic ok = 1'b0;
        if (who) begin
            bif.m_req = 1'b1; bif.m_addr = addr; bif.m_write = wr; bif.m_wdata = wd;
        end else begin
            bif.f_req = 1'b1; bif.f_addr = addr; bif.f_write = wr; bif.f_wdata = wd;
        end
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            ok = who ? bif.m_gnt : bif.f_gnt;
        end
        if (who) begin
            bif.m_req = 1'b0; bif.m_addr = ~addr; bif.m_write = ~wr; bif.m_wdata = ~wd;
        end else begin
            bif.f_req = 1'b0; bif.f_addr = ~addr; bif.f_write = ~wr; bif.f_wdata = ~wd;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout who=%0d actual=no_grant required=grant", who);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && expq.size() != 0; i++) @(negedge clock);
        repeat (2) @(negedge clock);
    endtask

    // monitor: every grant/done pulse is matched against the head of the expectation queue
    initial forever begin
        @(negedge clock);
        if (bif.f_gnt) on_evt(1'b0, 1'b0);
        if (bif.m_gnt) on_evt(1'b0, 1'b1);
        if (bif.f_done) on_evt(1'b1, 1'b0);
        if (bif.m_done) on_evt(1'b1, 1'b1);
    end

    // bus slave: answers each NONSEQ with cfg_wait wait states and an address-derived read word
    initial begin
        bif.bus_ready = 1'b1;
        bif.bus_response = 1'b0;
        bif.bus_read_data = 32'h0;
        forever begin
            @(negedge clock);
            if (bif.bus_trans == 2'b10) begin
                bif.bus_read_data = rd_model(bif.bus_address);
                bif.bus_response = bif.bus_address == cfg_err_addr;
                repeat (cfg_wait) begin
                    @(negedge clock);
                    bif.bus_ready = 1'b0;
                end
                @(negedge clock);
                bif.bus_ready = 1'b1;
            end else begin
                bif.bus_ready = !hold_ready;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        first_who = 1'b0;
`else
        first_who = 1'b1;
`endif
        last_rd = '{32'h0, 32'h0};
        last_gnt = '{0, 0};
        {bif.f_req, bif.f_write, bif.m_req, bif.m_write} = 4'b0;
        {bif.f_addr, bif.f_wdata, bif.m_addr, bif.m_wdata} = 128'h0;
        repeat (3) @(negedge clock);
        chk("reset_ctrl_flags", 32'({bif.bus_trans, bif.bus_write, bif.f_gnt, bif.m_gnt,
                                     bif.f_done, bif.m_done, bif.f_err, bif.m_err}), 32'h0);
        chk("reset_bus_address", bif.bus_address, 32'h0);
        chk("reset_bus_write_data", bif.bus_write_data, 32'h0);
        chk("reset_f_rdata", bif.f_rdata, 32'h0);
        chk("reset_m_rdata", bif.m_rdata, 32'h0);
        reset = 1'b0;

        push_gnt(1'b0, 32'h100, 1'b0, 32'h0);
        push_done(1'b0, 32'hDEAD_BEEF, 1'b0, 2);
        do_req(1'b0, 32'h100, 1'b0, 32'h0);
        @(negedge clock);
        chk("nonseq_one_cycle", 32'(bif.bus_trans), 32'h0);
        wait_drain();

        cfg_wait = 3;
        push_xfer(1'b1, 32'h2000, 1'b1, 32'h55, 5);
        do_req(1'b1, 32'h2000, 1'b1, 32'h55);
        repeat (3) begin
            @(negedge clock);
            chk("wait_bus_address", bif.bus_address, 32'h2000);
            chk("wait_bus_write_data", bif.bus_write_data, 32'h55);
            chk("wait_flags", 32'({bif.bus_write, bif.bus_trans, bif.m_done}), 32'b1000);
        end
        wait_drain();

        cfg_wait = 0;
        for (int t = 0; t < 2; t++) begin
            if (first_who) begin
                push_xfer(1'b1, 32'h3000 + 32'(t * 16), 1'b1, 32'hA0 + 32'(t), 2);
                push_xfer(1'b0, 32'h1000 + 32'(t * 16), 1'b0, 32'hF0, 2);
            end else begin
                push_xfer(1'b0, 32'h1000 + 32'(t * 16), 1'b0, 32'hF0, 2);
                push_xfer(1'b1, 32'h3000 + 32'(t * 16), 1'b1, 32'hA0 + 32'(t), 2);
            end
            fork
                do_req(1'b0, 32'h1000 + 32'(t * 16), 1'b0, 32'hF0);
                do_req(1'b1, 32'h3000 + 32'(t * 16), 1'b1, 32'hA0 + 32'(t));
            join
            wait_drain();
        end

        cfg_err_addr = 32'h300;
        push_gnt(1'b0, 32'h300, 1'b0, 32'h0);
        push_done(1'b0, 32'h0, 1'b1, 2);
        do_req(1'b0, 32'h300, 1'b0, 32'h0);
        wait_drain();
        cfg_err_addr = 32'hFFFF_FFFF;
        push_xfer(1'b0, 32'h304, 1'b0, 32'h0, 2);
        do_req(1'b0, 32'h304, 1'b0, 32'h0);
        wait_drain();

        cfg_wait = 2;
        push_xfer(1'b1, 32'h4000, 1'b0, 32'h0, 4);
        push_xfer(1'b0, 32'h500, 1'b0, 32'h0, 4);
        fork
            do_req(1'b1, 32'h4000, 1'b0, 32'h0);
            begin
                repeat (2) @(negedge clock);
                do_req(1'b0, 32'h500, 1'b0, 32'h0);
            end
        join
        wait_drain();

        cfg_wait = 0;
        hold_ready = 1'b1;
        repeat (2) @(negedge clock);
        bif.f_req = 1'b1; bif.f_addr = 32'h600; bif.f_write = 1'b0; bif.f_wdata = 32'h0;
        repeat (3) begin
            @(negedge clock);
            chk("not_ready_no_grant", 32'({bif.f_gnt, bif.m_gnt, bif.bus_trans}), 32'h0);
        end
        push_xfer(1'b0, 32'h600, 1'b0, 32'h0, 2);
        hold_ready = 1'b0;
        do_req(1'b0, 32'h600, 1'b0, 32'h0);
        wait_drain();

        cfg_wait = 5;
        push_gnt(1'b1, 32'h7000, 1'b0, 32'h0);
        do_req(1'b1, 32'h7000, 1'b0, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midreset_trans_idle", 32'(bif.bus_trans), 32'h0);
        chk("midreset_no_done", 32'({bif.m_done, bif.f_done}), 32'h0);
        chk("midreset_m_rdata", bif.m_rdata, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        last_rd = '{32'h0, 32'h0};
        repeat (8) @(negedge clock);
        cfg_wait = 0;
        push_xfer(1'b0, 32'h800, 1'b0, 32'h0, 2);
        do_req(1'b0, 32'h800, 1'b0, 32'h0);
        wait_drain();

        chk("scoreboard_empty", 32'(expq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
